uart_csr: RTL and testbench

//  Memory-mapped register front-end sitting directly upstream of the UART core, between the core data bus and the UART's
//  we/re/ce/req/gnt port. Decodes word offsets, drives single-cycle TX-FIFO pushes and RX-FIFO pops, and owns a status

---
 rtl/uart_pkg.sv | 30 +++
 rtl/uart_irq_ctrl.sv | 43 ++++
 rtl/uart_csr.sv | 192 +++++++++++++++++++
 tb/tb_uart_csr.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - register map, status/irq bit indices and FSM state type shared by uart_csr and uart_irq_ctrl
package uart_pkg;

    // Word offsets (byte address >> 2)
    localparam int unsigned OFF_TXDATA   = 0;
    localparam int unsigned OFF_RXDATA   = 1;
    localparam int unsigned OFF_STATUS   = 2;
    localparam int unsigned OFF_IRQ_EN   = 3;
    localparam int unsigned OFF_IRQ_PEND = 4;

    localparam int ST_RX_AVAIL = 0;
    localparam int ST_TX_FULL  = 1;
    localparam int ST_TX_DROP  = 2;
    localparam int ST_RX_UNDER = 3;
    localparam int ST_TIMEOUT  = 4;
    localparam int STATUS_W    = 5;

    localparam int IRQ_RX = 0;
    localparam int IRQ_TX = 1;
    localparam int IRQ_W  = 2;

    typedef logic [1:0] state_bits_t;

    typedef enum state_bits_t {
        S_IDLE     = 2'd0,
        S_WAIT_GNT = 2'd1,
        S_RESP     = 2'd2
    } state_e;

endpackage

// File: rtl/uart_irq_ctrl.sv
// rtl/uart_irq_ctrl.sv - rising-edge latch of UART level IRQs into W1C pending bits, enable mask and irq_o
module uart_irq_ctrl
    import uart_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [IRQ_W-1:0] irq_lvl_i,
    input  logic             en_we_i,
    input  logic [IRQ_W-1:0] en_wdata_i,
    input  logic [IRQ_W-1:0] pend_w1c_i,
    output logic [IRQ_W-1:0] irq_en_o,
    output logic [IRQ_W-1:0] irq_pend_o,
    output logic             irq_o
);

    logic [IRQ_W-1:0] en_q, en_d;
    logic [IRQ_W-1:0] pend_q, pend_d;
    logic [IRQ_W-1:0] prev_q, prev_d;

    always_comb begin
        en_d   = en_we_i ? en_wdata_i : en_q;
        prev_d = irq_lvl_i;
        // A new edge arriving with a W1C of the same bit leaves it pending.
        pend_d = (pend_q & ~pend_w1c_i) | (irq_lvl_i & ~prev_q);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            en_q   <= '0;
            pend_q <= '0;
            prev_q <= '0;
        end else begin
            en_q   <= en_d;
            pend_q <= pend_d;
            prev_q <= prev_d;
        end
    end

    assign irq_en_o   = en_q;
    assign irq_pend_o = pend_q;
    assign irq_o      = |(pend_q & en_q);

endmodule

// File: rtl/uart_csr.sv
// rtl/uart_csr.sv - register front-end for the UART core: decode, TX push / RX pop handshake, sticky status, irq
// Optional grant timeout in WAIT_GNT enabled by defining UART_CSR_TIMEOUT_EN.
module uart_csr
    import uart_pkg::*;
#(
    parameter int ADDR_W  = 5,
    parameter int TIMEOUT = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              bus_req_i,
    input  logic              bus_we_i,
    input  logic [ADDR_W-1:0] bus_addr_i,
    input  logic [31:0]       bus_wdata_i,
    output logic              bus_gnt_o,
    output logic              bus_rvalid_o,
    output logic [31:0]       bus_rdata_o,
    output logic              uart_ce_o,
    output logic              uart_req_o,
    input  logic              uart_gnt_i,
    output logic              uart_we_o,
    output logic              uart_re_o,
    output logic [31:0]       uart_tx_wdata_o,
    input  logic [31:0]       uart_rx_rdata_i,
    input  logic [1:0]        uart_irq_i,
    output logic              irq_o
);

    state_e      state_q, state_d;
    logic        is_tx_q, is_tx_d;
    logic [7:0]  byte_q, byte_d;
    logic [31:0] rdata_q, rdata_d;
    logic [ST_TIMEOUT:ST_TX_DROP] sticky_q, sticky_d;
    logic [ST_TIMEOUT:ST_TX_DROP] set_flags, clr_flags;

    logic             en_we;
    logic [IRQ_W-1:0] pend_w1c;
    logic [IRQ_W-1:0] irq_en;
    logic [IRQ_W-1:0] irq_pend;
    logic             tmo_hit;

    logic [ADDR_W-3:0]   word;
    logic                hit_tx, hit_rx, hit_status, hit_en, hit_pend;
    logic [STATUS_W-1:0] status_rd;

    assign word       = bus_addr_i[ADDR_W-1:2];
    assign hit_tx     = (32'(word) == OFF_TXDATA);
    assign hit_rx     = (32'(word) == OFF_RXDATA);
    assign hit_status = (32'(word) == OFF_STATUS);
    assign hit_en     = (32'(word) == OFF_IRQ_EN);
    assign hit_pend   = (32'(word) == OFF_IRQ_PEND);
    assign status_rd  = {sticky_q, uart_irq_i[IRQ_TX], uart_irq_i[IRQ_RX]};

`ifdef UART_CSR_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign tmo_hit = (state_q == S_WAIT_GNT) && (cnt_q == CNT_W'(TIMEOUT));

    always_comb begin
        cnt_d = '0;
        if (state_q == S_WAIT_GNT && !tmo_hit) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    logic unused_tmo_cfg;

    assign tmo_hit        = 1'b0;
    assign unused_tmo_cfg = (TIMEOUT != 0);
`endif

    always_comb begin
        state_d         = state_q;
        is_tx_d         = is_tx_q;
        byte_d          = byte_q;
        rdata_d         = rdata_q;
        set_flags       = '0;
        clr_flags       = '0;
        en_we           = 1'b0;
        pend_w1c        = '0;
        bus_gnt_o       = 1'b0;
        bus_rvalid_o    = 1'b0;
        bus_rdata_o     = '0;
        uart_ce_o       = 1'b0;
        uart_req_o      = 1'b0;
        uart_we_o       = 1'b0;
        uart_re_o       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus_req_i) begin
                    bus_gnt_o = 1'b1;
                    is_tx_d   = bus_we_i;
                    byte_d    = bus_wdata_i[7:0];
                    rdata_d   = '0;
                    state_d   = S_RESP;
                    if (bus_we_i) begin
                        if (hit_tx) begin
                            if (uart_irq_i[IRQ_TX]) set_flags[ST_TX_DROP] = 1'b1;
                            else                    state_d = S_WAIT_GNT;
                        end else if (hit_status) begin
                            clr_flags = bus_wdata_i[ST_TIMEOUT:ST_TX_DROP];
                        end else if (hit_en) begin
                            en_we = 1'b1;
                        end else if (hit_pend) begin
                            pend_w1c = bus_wdata_i[IRQ_W-1:0];
                        end
                    end else begin
                        if (hit_rx) begin
                            if (uart_irq_i[IRQ_RX]) state_d = S_WAIT_GNT;
                            else                    set_flags[ST_RX_UNDER] = 1'b1;
                        end else if (hit_status) begin
                            rdata_d = 32'(status_rd);
                        end else if (hit_en) begin
                            rdata_d = 32'(irq_en);
                        end else if (hit_pend) begin
                            rdata_d = 32'(irq_pend);
                        end
                    end
                end
            end
            S_WAIT_GNT: begin
                if (tmo_hit) begin
                    set_flags[ST_TIMEOUT] = 1'b1;
                    state_d               = S_RESP;
                end else begin
                    uart_ce_o  = 1'b1;
                    uart_req_o = 1'b1;
                    if (uart_gnt_i) begin
                        uart_we_o = is_tx_q;
                        uart_re_o = !is_tx_q;
                        // The RX head is only valid in the pop cycle, so capture it here.
                        if (!is_tx_q) rdata_d = 32'(uart_rx_rdata_i[7:0]);
                        state_d = S_RESP;
                    end
                end
            end
            S_RESP: begin
                bus_rvalid_o = 1'b1;
                bus_rdata_o  = rdata_q;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        sticky_d = (sticky_q & ~clr_flags) | set_flags;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= S_IDLE;
            is_tx_q  <= 1'b0;
            byte_q   <= '0;
            rdata_q  <= '0;
            sticky_q <= '0;
        end else begin
            state_q  <= state_d;
            is_tx_q  <= is_tx_d;
            byte_q   <= byte_d;
            rdata_q  <= rdata_d;
            sticky_q <= sticky_d;
        end
    end

    assign uart_tx_wdata_o = {24'h0, byte_q};

    uart_irq_ctrl u_irq_ctrl (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .irq_lvl_i  (uart_irq_i),
        .en_we_i    (en_we),
        .en_wdata_i (bus_wdata_i[IRQ_W-1:0]),
        .pend_w1c_i (pend_w1c),
        .irq_en_o   (irq_en),
        .irq_pend_o (irq_pend),
        .irq_o      (irq_o)
    );

    logic unused_ok;
    assign unused_ok = ^{bus_addr_i[1:0], bus_wdata_i[31:8], uart_rx_rdata_i[31:8]};

endmodule

// File: tb/tb_uart_csr.sv
// tb/tb_uart_csr.sv - directed bench for uart_csr with a per-cycle behavioural model of the register front-end
`timescale 1ns/1ps
module tb_uart_csr;

    localparam int TIMEOUT = 16;
`ifdef UART_CSR_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        bus_req = 1'b0;
    logic        bus_we = 1'b0;
    logic [4:0]  bus_addr = '0;
    logic [31:0] bus_wdata = '0;
    logic        bus_gnt, bus_rvalid;
    logic [31:0] bus_rdata;
    logic        uart_ce, uart_req, uart_gnt, uart_we, uart_re;
    logic [31:0] uart_tx_wdata;
    logic [31:0] uart_rx_rdata;
    logic [1:0]  uart_irq = 2'b00;
    logic        irq;
    logic        auto_gnt = 1'b1;
    logic        man_gnt = 1'b0;
    logic [7:0]  rx_head = 8'h5A;

    assign uart_gnt      = auto_gnt ? (uart_req & uart_ce) : man_gnt;
    assign uart_rx_rdata = {24'h0, rx_head};

    uart_csr #(.ADDR_W(5), .TIMEOUT(TIMEOUT)) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .bus_req_i       (bus_req),
        .bus_we_i        (bus_we),
        .bus_addr_i      (bus_addr),
        .bus_wdata_i     (bus_wdata),
        .bus_gnt_o       (bus_gnt),
        .bus_rvalid_o    (bus_rvalid),
        .bus_rdata_o     (bus_rdata),
        .uart_ce_o       (uart_ce),
        .uart_req_o      (uart_req),
        .uart_gnt_i      (uart_gnt),
        .uart_we_o       (uart_we),
        .uart_re_o       (uart_re),
        .uart_tx_wdata_o (uart_tx_wdata),
        .uart_rx_rdata_i (uart_rx_rdata),
        .uart_irq_i      (uart_irq),
        .irq_o           (irq)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Spec-level model: register contents plus where the current bus transaction stands.
    logic [1:0]  m_en = '0, m_pend = '0, m_prev = '0;
    logic [4:2]  m_flags = '0;
    logic        m_wait_st = 1'b0, m_resp_st = 1'b0, m_is_tx = 1'b0;
    int          m_wait = 0;
    logic [7:0]  m_push = '0;
    logic [31:0] m_resp_data = '0;

    int          n_we = 0, n_re = 0, we_cyc = 0;
    logic [31:0] last_tx = '0;

    always @(negedge clk) begin : compare
        logic        exp_gnt, exp_ce, exp_we, exp_re, tmo_now, nxt_resp;
        logic [31:0] nxt_data;
        logic [4:2]  fl_set, fl_clr;
        logic [1:0]  pend_clr;
        logic [2:0]  off;
        if (!rst_n) begin
            check("rst_gnt", bus_gnt, 0);
            check("rst_rvalid", bus_rvalid, 0);
            check("rst_rdata", bus_rdata, 0);
            check("rst_ce", uart_ce, 0);
            check("rst_req", uart_req, 0);
            check("rst_we", uart_we, 0);
            check("rst_re", uart_re, 0);
            check("rst_txdata", uart_tx_wdata, 0);
            check("rst_irq", irq, 0);
            m_en = '0; m_pend = '0; m_prev = '0; m_flags = '0;
            m_wait_st = 1'b0; m_resp_st = 1'b0; m_is_tx = 1'b0; m_wait = 0;
            m_push = '0; m_resp_data = '0;
        end else begin
            tmo_now = TMO_EN && m_wait_st && (m_wait == TIMEOUT);
            exp_gnt = bus_req && !m_wait_st && !m_resp_st;
            exp_ce  = m_wait_st && !tmo_now;
            exp_we  = exp_ce && m_is_tx && uart_gnt;
            exp_re  = exp_ce && !m_is_tx && uart_gnt;

            check("bus_gnt", bus_gnt, exp_gnt);
            check("bus_rvalid", bus_rvalid, m_resp_st);
            check("bus_rdata", bus_rdata, m_resp_st ? m_resp_data : 32'h0);
            check("uart_ce", uart_ce, exp_ce);
            check("uart_req", uart_req, exp_ce);
            check("uart_we", uart_we, exp_we);
            check("uart_re", uart_re, exp_re);
            check("irq_o", irq, |(m_pend & m_en));
            if (uart_we) check("tx_wdata", uart_tx_wdata, {24'h0, m_push});

            if (uart_we) begin n_we++; we_cyc = cyc; last_tx = uart_tx_wdata; end
            if (uart_re) n_re++;

            fl_set = '0; fl_clr = '0; pend_clr = '0; nxt_resp = 1'b0; nxt_data = '0;
            if (exp_gnt) begin
                off      = bus_addr[4:2];
                nxt_resp = 1'b1;
                if (bus_we) begin
                    case (off)
                        3'd0: if (uart_irq[1]) fl_set[2] = 1'b1;
                              else begin
                                  nxt_resp = 1'b0; m_wait_st = 1'b1; m_wait = 0;
                                  m_is_tx = 1'b1; m_push = bus_wdata[7:0];
                              end
                        3'd2: fl_clr = bus_wdata[4:2];
                        3'd3: m_en = bus_wdata[1:0];
                        3'd4: pend_clr = bus_wdata[1:0];
                        default: ;
                    endcase
                end else begin
                    case (off)
                        3'd1: if (!uart_irq[0]) fl_set[3] = 1'b1;
                              else begin
                                  nxt_resp = 1'b0; m_wait_st = 1'b1; m_wait = 0; m_is_tx = 1'b0;
                              end
                        3'd2: nxt_data = {27'h0, m_flags, uart_irq};
                        3'd3: nxt_data = {30'h0, m_en};
                        3'd4: nxt_data = {30'h0, m_pend};
                        default: ;
                    endcase
                end
            end else if (m_wait_st) begin
                if (exp_we || exp_re) begin
                    m_wait_st = 1'b0; nxt_resp = 1'b1;
                    nxt_data = exp_re ? {24'h0, uart_rx_rdata[7:0]} : 32'h0;
                end else if (tmo_now) begin
                    m_wait_st = 1'b0; nxt_resp = 1'b1; fl_set[4] = 1'b1;
                end else begin
                    m_wait++;
                end
            end
            m_resp_st   = nxt_resp;
            m_resp_data = nxt_data;
            m_flags     = (m_flags & ~fl_clr) | fl_set;
            m_pend      = (m_pend & ~pend_clr) | (uart_irq & ~m_prev);
            m_prev      = uart_irq;
        end
    end

    task automatic bus_xfer(input logic we, input logic [4:0] addr, input logic [31:0] wdata,
                            output logic [31:0] rdata, output int lat);
        int  start;
        logic got;
        @(posedge clk); #1;
        bus_req = 1'b1; bus_we = we; bus_addr = addr; bus_wdata = wdata;
        got = 1'b0;
        for (int n = 0; n < 50 && !got; n++) begin
            @(negedge clk);
            got = bus_gnt;
        end
        check("xfer_gnt_seen", got, 1);
        start = cyc;
        @(posedge clk); #1;
        bus_req = 1'b0; bus_we = 1'b0; bus_addr = '0; bus_wdata = '0;
        got = 1'b0;
        for (int n = 0; n < 100 && !got; n++) begin
            @(negedge clk);
            got = bus_rvalid;
        end
        check("xfer_rvalid_seen", got, 1);
        rdata = bus_rdata;
        lat   = cyc - start;
        #1;
    endtask

    logic [31:0] rd;
    int          lat, we0, re0, gcyc;

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // TX push, immediate grant: we one cycle after gnt, rvalid two cycles after.
        we0 = n_we;
        bus_xfer(1'b1, 5'h00, 32'h41, rd, lat);
        gcyc = cyc - lat;
        check("tx_latency", lat, 2);
        check("tx_push_count", n_we - we0, 1);
        check("tx_we_cycle", we_cyc - gcyc, 1);
        check("tx_data", last_tx, 32'h41);

        // RX pop with data available.
        uart_irq = 2'b01;
        re0 = n_re;
        bus_xfer(1'b0, 5'h04, 32'h0, rd, lat);
        check("rx_rdata", rd, 32'h5A);
        check("rx_pop_count", n_re - re0, 1);
        check("rx_latency", lat, 2);

        // RX underflow, then W1C of RX_UNDER.
        uart_irq = 2'b00;
        re0 = n_re;
        bus_xfer(1'b0, 5'h04, 32'h0, rd, lat);
        check("under_rdata", rd, 32'h0);
        check("under_no_pop", n_re - re0, 0);
        check("under_latency", lat, 1);
        bus_xfer(1'b0, 5'h08, 32'h0, rd, lat);
        check("status_under", rd, 32'h08);
        bus_xfer(1'b1, 5'h08, 32'h08, rd, lat);
        bus_xfer(1'b0, 5'h08, 32'h0, rd, lat);
        check("status_cleared", rd, 32'h00);

        // TX while full: drop flag, pending bits, enable mask.
        uart_irq = 2'b10;
        we0 = n_we;
        bus_xfer(1'b1, 5'h00, 32'h77, rd, lat);
        check("drop_no_push", n_we - we0, 0);
        bus_xfer(1'b0, 5'h08, 32'h0, rd, lat);
        check("status_drop", rd, 32'h06);
        bus_xfer(1'b0, 5'h10, 32'h0, rd, lat);
        check("pend_both", rd, 32'h3);
        check("irq_masked", irq, 0);
        bus_xfer(1'b1, 5'h0C, 32'h2, rd, lat);
        check("irq_enabled", irq, 1);
        bus_xfer(1'b1, 5'h10, 32'h2, rd, lat);
        check("irq_cleared", irq, 0);
        bus_xfer(1'b0, 5'h10, 32'h0, rd, lat);
        check("pend_rx_only", rd, 32'h1);
        bus_xfer(1'b1, 5'h10, 32'h3, rd, lat);

        // W1C of IRQ_PEND[1] in the same cycle as its rising edge: set wins.
        uart_irq = 2'b00;
        repeat (2) @(posedge clk);
        fork
            bus_xfer(1'b1, 5'h10, 32'h2, rd, lat);
            begin @(posedge clk); #1 uart_irq = 2'b10; end
        join
        bus_xfer(1'b0, 5'h10, 32'h0, rd, lat);
        check("pend_set_wins", rd, 32'h2);
        check("irq_set_wins", irq, 1);
        uart_irq = 2'b00;
        bus_xfer(1'b1, 5'h10, 32'h2, rd, lat);
        bus_xfer(1'b1, 5'h08, 32'h1C, rd, lat);
        bus_xfer(1'b0, 5'h08, 32'h0, rd, lat);
        check("status_all_clear", rd, 32'h0);

        // Unmapped offsets and write-only TXDATA read back as zero.
        bus_xfer(1'b1, 5'h14, 32'hFFFF_FFFF, rd, lat);
        bus_xfer(1'b0, 5'h14, 32'h0, rd, lat);
        check("unmapped_14", rd, 32'h0);
        bus_xfer(1'b0, 5'h1C, 32'h0, rd, lat);
        check("unmapped_1c", rd, 32'h0);
        bus_xfer(1'b0, 5'h00, 32'h0, rd, lat);
        check("txdata_read", rd, 32'h0);
        check("unmapped_latency", lat, 1);

        // Slow UART grant.
        auto_gnt = 1'b0;
        we0 = n_we;
`ifdef UART_CSR_TIMEOUT_EN
        fork
            bus_xfer(1'b1, 5'h00, 32'h99, rd, lat);
            begin repeat (20) @(negedge clk); end
        join
        check("tmo_latency", lat, TIMEOUT + 2);
        check("tmo_no_push", n_we - we0, 0);
        bus_xfer(1'b0, 5'h08, 32'h0, rd, lat);
        check("status_tmo", rd, 32'h10);
        bus_xfer(1'b1, 5'h08, 32'h10, rd, lat);
`else
        fork
            bus_xfer(1'b1, 5'h00, 32'h99, rd, lat);
            begin
                repeat (20) @(negedge clk);
                check("wait_hold_ce", uart_ce, 1);
                @(posedge clk); #1 man_gnt = 1'b1;
                @(posedge clk); #1 man_gnt = 1'b0;
            end
        join
        check("slow_latency", lat, 21);
        check("slow_push", n_we - we0, 1);
        check("slow_data", last_tx, 32'h99);
        bus_xfer(1'b0, 5'h08, 32'h0, rd, lat);
        check("status_no_tmo", rd, 32'h0);
`endif

        // Asynchronous reset while waiting for the UART grant.
        auto_gnt = 1'b1;
        bus_xfer(1'b1, 5'h0C, 32'h3, rd, lat);
        auto_gnt = 1'b0;
        @(posedge clk); #1;
        bus_req = 1'b1; bus_we = 1'b1; bus_addr = 5'h00; bus_wdata = 32'h55;
        @(negedge clk);
        check("mid_gnt", bus_gnt, 1);
        @(posedge clk); #1;
        bus_req = 1'b0; bus_we = 1'b0; bus_wdata = '0;
        @(negedge clk);
        check("mid_ce_before", uart_ce, 1);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("mid_ce_after", uart_ce, 0);
        check("mid_req_after", uart_req, 0);
        check("mid_rvalid_after", bus_rvalid, 0);
        check("mid_txdata_after", uart_tx_wdata, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        auto_gnt = 1'b1;
        we0 = n_we;
        bus_xfer(1'b1, 5'h00, 32'h33, rd, lat);
        check("post_rst_latency", lat, 2);
        check("post_rst_push", n_we - we0, 1);
        check("post_rst_data", last_tx, 32'h33);
        bus_xfer(1'b0, 5'h0C, 32'h0, rd, lat);
        check("post_rst_irq_en", rd, 32'h0);

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
